parity_frame_tx: RTL and testbench

Serial transmitter that takes a parallel word over a valid/ready handshake and frames it as start bit, data LSB-first, parity bit and stop bit. Parity comes from a reduction-XOR of the word. Data shifts out with a logical right shift, and each bit is held for a programmable number of clocks. The block consumes the output of the team's reduction/parity and shift stages and produces the single-wire serial stream.

---
 rtl/parity_frame_tx_pkg.sv | 20 ++
 rtl/parity_frame_tx_bit_tick_gen.sv | 28 ++
 rtl/parity_frame_tx.sv | 109 ++++++++++
 tb/tb_parity_frame_tx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_tx_pkg.sv
// parity_frame_tx_pkg: shared state encoding and sizing helpers for the parity frame transmitter.
package parity_frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic int clog2c(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int frame_len(input int width, input int clks_per_bit);
        return (width + 3) * clks_per_bit;
    endfunction

endpackage

// File: rtl/parity_frame_tx_bit_tick_gen.sv
// bit_tick_gen: baud counter that pulses tick on the last clock of each serial bit.
module bit_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    import parity_frame_tx_pkg::*;

    localparam int CW = clog2c(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = clear ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: frames a handshaken word as start, data LSB-first, parity and stop bits
// on a registered idle-high serial line.
module parity_frame_tx #(
    parameter int WIDTH        = 5,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);
    import parity_frame_tx_pkg::*;

    localparam int BW = clog2c(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              tick;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx_out   = tx_q;
    assign done     = done_q;

    // Counter is held at zero while idle so every frame starts on a fresh bit period.
    bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == IDLE),
        .enable (state_q != IDLE),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (in_valid) begin
                    shift_d = in_data;
                    par_d   = (^in_data) ^ (ODD_PARITY != 0);
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: if (tick) begin
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: if (tick) begin
                if (bit_q == BW'(WIDTH - 1)) begin
                    tx_d    = par_q;
                    state_d = PARITY;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                end
            end
            PARITY: if (tick) begin
                tx_d    = 1'b1;
                state_d = STOP;
            end
            STOP: if (tick) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: table vectors, hand sequences and random frames for three parameterisations,
// checked cycle by cycle against a frame-level model.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] in_data [3];
    logic       in_valid [3];
    logic       rdy_o [3];
    logic       tx_o [3];
    logic       busy_o [3];
    logic       done_o [3];

    int wv[3] = '{5, 5, 1};
    int cv[3] = '{4, 4, 1};
    int ov[3] = '{0, 1, 0};

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.WIDTH(5), .CLKS_PER_BIT(4), .ODD_PARITY(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(rdy_o[0]), .tx_out(tx_o[0]), .busy(busy_o[0]), .done(done_o[0]));

    parity_frame_tx #(.WIDTH(5), .CLKS_PER_BIT(4), .ODD_PARITY(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(rdy_o[1]), .tx_out(tx_o[1]), .busy(busy_o[1]), .done(done_o[1]));

    parity_frame_tx #(.WIDTH(1), .CLKS_PER_BIT(1), .ODD_PARITY(0)) d2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[2][0:0]), .in_valid(in_valid[2]),
        .in_ready(rdy_o[2]), .tx_out(tx_o[2]), .busy(busy_o[2]), .done(done_o[2]));

    typedef struct {
        int         dut;
        logic [4:0] data;
        logic [7:0] bits;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Frame as a list of line levels: start, data LSB-first, parity, stop.
    function automatic logic [7:0] model(input logic [4:0] d, input int w, input int odd);
        logic [7:0] b;
        int ones;
        b = 8'h00;
        ones = 0;
        for (int i = 0; i < w; i++) begin
            b[1 + i] = d[i];
            ones += int'(d[i]);
        end
        b[w + 1] = 1'((ones % 2) ^ odd);
        b[w + 2] = 1'b1;
        return b;
    endfunction

    task automatic chk_idle(input int d, input string tag);
        chk({tag, " tx"}, int'(tx_o[d]), 1);
        chk({tag, " in_ready"}, int'(rdy_o[d]), 1);
        chk({tag, " busy"}, int'(busy_o[d]), 0);
        chk({tag, " done"}, int'(done_o[d]), 0);
    endtask

    // Called one step after the acceptance edge; ends one step after the done edge.
    task automatic check_frame(input int d, input logic [7:0] bits, input bit garble);
        int len;
        len = (wv[d] + 3) * cv[d];
        for (int k = 0; k < len; k++) begin
            chk("frame tx", int'(tx_o[d]), int'(bits[k / cv[d]]));
            chk("frame busy", int'(busy_o[d]), 1);
            chk("frame in_ready", int'(rdy_o[d]), 0);
            chk("frame done", int'(done_o[d]), 0);
            if (garble) begin
                in_data[d]  = 5'($urandom);
                in_valid[d] = (k < len - 1) ? 1'($urandom) : 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("end done", int'(done_o[d]), 1);
        chk("end busy", int'(busy_o[d]), 0);
        chk("end tx", int'(tx_o[d]), 1);
        chk("end in_ready", int'(rdy_o[d]), 1);
    endtask

    task automatic send(input int d, input logic [4:0] data, input logic [7:0] bits, input bit garble);
        @(negedge clk);
        in_data[d]  = data;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        check_frame(d, bits, garble);
        @(posedge clk); #1;
        chk("done width", int'(done_o[d]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 5'b10110, 8'b11101100};
        vecs[1] = '{1, 5'b11111, 8'b10111110};
        vecs[2] = '{1, 5'b00000, 8'b11000000};
        vecs[3] = '{0, 5'h03,    8'b10000110};
        vecs[4] = '{0, 5'h15,    8'b11101010};
        vecs[5] = '{2, 5'b00001, 8'b00001110};
        vecs[6] = '{2, 5'b00000, 8'b00001000};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data[i]  = '0;
            in_valid[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_idle(i, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk_idle(0, "idle");
        end

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].dut, vecs[i].data, vecs[i].bits, 1'b0);
            chk("table model", int'(model(vecs[i].data, wv[vecs[i].dut], ov[vecs[i].dut])), int'(vecs[i].bits));
        end

        // Back-to-back: valid held across the done cycle; second word presented while busy.
        @(negedge clk);
        in_data[0]  = 5'h15;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_data[0] = 5'h0A;
        check_frame(0, 8'b11101010, 1'b0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check_frame(0, 8'b10010100, 1'b0);
        @(posedge clk); #1;
        chk("b2b done low", int'(done_o[0]), 0);
        chk("b2b idle", int'(busy_o[0]), 0);

        // Abort during the third data bit, then a clean frame.
        @(negedge clk);
        in_data[0]  = 5'h03;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("abort pre busy", int'(busy_o[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle(0, "abort async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            chk_idle(0, "after abort");
        end
        send(0, 5'h03, 8'b10000110, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int d;
            logic [4:0] data;
            d = int'($urandom_range(0, 2));
            data = 5'($urandom);
            if (d == 2) data = {4'b0, data[0]};
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(d, data, model(data, wv[d], ov[d]), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
